// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment driver with a pending/active frame pair.
// New frames arrive through a valid/ready handshake and are swapped in only at
// the end of digit slot 3, so a displayed frame is never mixed with the next.
module sseg_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_digits,
  input  logic [3:0]  load_dp,
  input  logic [3:0]  load_den,
  output logic [7:0]  sseg,
  output logic [3:0]  anode,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       idx_reg, idx_next;

  logic [15:0] act_digits_reg, pend_digits_reg;
  logic [3:0]  act_dp_reg, pend_dp_reg;
  logic [3:0]  act_den_reg, pend_den_reg;
  logic        pend_full_reg;

  logic [7:0] sseg_reg, sseg_next;
  logic [3:0] anode_reg, anode_next;
  logic       frame_done_reg;

  logic       slot_end, frame_end, xfer, swap;
  logic [3:0] act_nib [4];
  logic [3:0] sel_onehot;
  logic [3:0] cur_nib;
  logic [6:0] seg7;
  logic       lit;

  // Slot/frame boundary detection and handshake qualifiers.
  always_comb begin
    slot_end  = en && (cnt_reg == CNT_LAST);
    frame_end = slot_end && (idx_reg == 2'd3);
    xfer      = load_valid && !pend_full_reg;
    // The boundary looks at pending before any same-edge capture.
    swap      = frame_end && pend_full_reg;
  end

  // Next slot counter and digit index; both freeze while en is low.
  always_comb begin
    cnt_next = cnt_reg;
    idx_next = idx_reg;
    if (slot_end) begin
      cnt_next = '0;
      idx_next = idx_reg + 2'd1;
    end else if (en) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // Scan position registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
    end
  end

  // Pending buffer: emptied by a swap, filled by a handshake transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_full_reg   <= 1'b0;
      pend_digits_reg <= '0;
      pend_dp_reg     <= '0;
      pend_den_reg    <= '0;
    end else begin
      if (swap) pend_full_reg <= 1'b0;
      if (xfer) begin
        pend_full_reg   <= 1'b1;
        pend_digits_reg <= load_digits;
        pend_dp_reg     <= load_dp;
        pend_den_reg    <= load_den;
      end
    end
  end

  // Active frame: replaced only at a frame boundary with a full pending buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_digits_reg <= '0;
      act_dp_reg     <= '0;
      act_den_reg    <= '0;
    end else if (swap) begin
      act_digits_reg <= pend_digits_reg;
      act_dp_reg     <= pend_dp_reg;
      act_den_reg    <= pend_den_reg;
    end
  end

  // Split the active frame into nibbles and build the anode one-hot per digit.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign act_nib[gi]    = act_digits_reg[4*gi +: 4];
    assign sel_onehot[gi] = (idx_reg == 2'(gi));
  end

  // Hex-to-segment decode of the current digit, segment order a..g.
  always_comb begin
    cur_nib = act_nib[idx_reg];
    seg7    = 7'b0000000;
    case (cur_nib)
      4'h0: seg7 = 7'b1111110;
      4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;
      4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;
      4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;
      4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;
      4'h9: seg7 = 7'b1111011;
      4'hA: seg7 = 7'b1110111;
      4'hB: seg7 = 7'b0011111;
      4'hC: seg7 = 7'b1001110;
      4'hD: seg7 = 7'b0111101;
      4'hE: seg7 = 7'b1001111;
      default: seg7 = 7'b1000111;
    endcase
  end

  // Output gating: dark while disabled, inside the blank gap, or digit disabled.
  always_comb begin
    lit        = en && (cnt_reg >= CNT_BLANK) && act_den_reg[idx_reg];
    sseg_next  = 8'h00;
    anode_next = 4'h0;
    if (lit) begin
      sseg_next  = {seg7, act_dp_reg[idx_reg]};
      anode_next = sel_onehot;
    end
  end

  // Registered outputs, so anode/segment lines switch together and glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sseg_reg       <= '0;
      anode_reg      <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      sseg_reg       <= sseg_next;
      anode_reg      <= anode_next;
      frame_done_reg <= frame_end;
    end
  end

  assign sseg       = sseg_reg;
  assign anode      = anode_reg;
  assign digit_idx  = idx_reg;
  assign frame_done = frame_done_reg;
  assign load_ready = !pend_full_reg;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: a time-based reference model checked every cycle,
// a table of frames with hand-decoded expectations, corner-case sequences and
// a randomized soak.
module tb_sseg_scan_ctrl;

  localparam int R  = 8;
  localparam int B  = 2;
  localparam int W  = 4;
  localparam int FR = 4 * R;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_digits = '0;
  logic [3:0]  load_dp = '0;
  logic [3:0]  load_den = '0;
  logic [7:0]  sseg;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        frame_done;

  sseg_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYC(B), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_digits(load_digits), .load_dp(load_dp), .load_den(load_den),
    .sseg(sseg), .anode(anode), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: position in the frame is a single count of enabled cycles.
  logic [6:0]  seg_tab [16];
  int          m_ticks;
  logic [15:0] m_act_dig, m_pend_dig;
  logic [3:0]  m_act_dp, m_act_den, m_pend_dp, m_pend_den;
  bit          m_pend_full;
  logic [7:0]  e_sseg;
  logic [3:0]  e_anode;
  logic [1:0]  e_idx;
  logic        e_fd, e_ready;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  den;
    logic [31:0] exp_sseg;  // slot s at [8*s +: 8]
    logic [15:0] exp_an;    // slot s at [4*s +: 4]
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_step();
    int cnt, slot;
    logic [3:0] nib;
    bit xfer;
    if (!rst_n) begin
      m_ticks = 0;
      m_act_dig = '0; m_act_dp = '0; m_act_den = '0;
      m_pend_full = 0;
      e_sseg = '0; e_anode = '0; e_fd = 1'b0;
    end else begin
      cnt  = m_ticks % R;
      slot = m_ticks / R;
      nib  = 4'(m_act_dig >> (slot * 4));
      if (en && cnt >= B && m_act_den[slot]) begin
        e_anode = 4'(1 << slot);
        e_sseg  = {seg_tab[nib], m_act_dp[slot]};
      end else begin
        e_anode = '0;
        e_sseg  = '0;
      end
      xfer = load_valid && !m_pend_full;
      e_fd = en && (m_ticks == FR - 1);
      if (e_fd && m_pend_full) begin
        m_act_dig = m_pend_dig; m_act_dp = m_pend_dp; m_act_den = m_pend_den;
        m_pend_full = 0;
      end
      if (xfer) begin
        m_pend_dig = load_digits; m_pend_dp = load_dp; m_pend_den = load_den;
        m_pend_full = 1;
      end
      if (en) m_ticks = (m_ticks + 1) % FR;
    end
    e_idx   = 2'(m_ticks / R);
    e_ready = !m_pend_full;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("sseg", 32'(sseg), 32'(e_sseg));
    chk("anode", 32'(anode), 32'(e_anode));
    chk("digit_idx", 32'(digit_idx), 32'(e_idx));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("load_ready", 32'(load_ready), 32'(e_ready));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_fd();
    bit found = 0;
    for (int i = 0; i < 3 * FR && !found; i++) begin
      tick();
      found = frame_done;
    end
    chk("frame_done seen", 32'(found), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] n);
    bit done = 0;
    load_digits = d; load_dp = p; load_den = n; load_valid = 1'b1;
    for (int i = 0; i < 3 * FR && !done; i++) begin
      done = load_ready;
      tick();
    end
    load_valid = 1'b0;
    chk("load accepted", 32'(done), 32'd1);
    $display("load digits=%h dp=%b den=%b", d, p, n);
  endtask

  initial begin
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    vecs[0] = '{dig: 16'h0CE5, dp: 4'b0001, den: 4'hF,
                exp_sseg: {8'hFC, 8'h9C, 8'h9E, 8'hB7}, exp_an: {4'h8, 4'h4, 4'h2, 4'h1}};
    vecs[1] = '{dig: 16'h1234, dp: 4'b0000, den: 4'hF,
                exp_sseg: {8'h60, 8'hDA, 8'hF2, 8'h66}, exp_an: {4'h8, 4'h4, 4'h2, 4'h1}};
    vecs[2] = '{dig: 16'hABDF, dp: 4'b1010, den: 4'b1010,
                exp_sseg: {8'hEF, 8'h00, 8'h7B, 8'h00}, exp_an: {4'h8, 4'h0, 4'h2, 4'h0}};
    vecs[3] = '{dig: 16'h8967, dp: 4'b1111, den: 4'b0101,
                exp_sseg: {8'h00, 8'hF7, 8'h00, 8'hE1}, exp_an: {4'h0, 4'h4, 4'h0, 4'h1}};

    // Reset state, then a dark display for one full frame.
    rst_n = 1'b0; en = 1'b1;
    ticks(3);
    chk("reset anode", 32'(anode), 32'd0);
    chk("reset sseg", 32'(sseg), 32'd0);
    chk("reset ready", 32'(load_ready), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < FR; i++) begin
      tick();
      chk("dark after reset", 32'(anode), 32'd0);
    end

    // Table-driven frames: load, wait for the swap, check every cycle of the frame.
    for (int v = 0; v < 4; v++) begin
      do_load(vecs[v].dig, vecs[v].dp, vecs[v].den);
      wait_fd();
      for (int m = 1; m <= FR; m++) begin
        int t, s, c;
        tick();
        t = m - 1; s = t / R; c = t % R;
        chk($sformatf("vec%0d sseg", v), 32'(sseg),
            (c < B) ? 32'd0 : 32'(vecs[v].exp_sseg[8*s +: 8]));
        chk($sformatf("vec%0d anode", v), 32'(anode),
            (c < B) ? 32'd0 : 32'(vecs[v].exp_an[4*s +: 4]));
      end
      $display("vector %0d digits=%h checked", v, vecs[v].dig);
    end

    // Backpressure: a second load is held off until the first has been swapped in.
    begin
      bit seen = 0;
      wait_fd();
      load_digits = 16'h4321; load_dp = 4'h0; load_den = 4'hF; load_valid = 1'b1;
      tick();
      chk("bp ready drop", 32'(load_ready), 32'd0);
      load_digits = 16'h5678;
      for (int i = 0; i < 3 * FR && !seen; i++) begin
        tick();
        seen = frame_done;
        if (!seen) chk("bp held off", 32'(load_ready), 32'd0);
      end
      chk("bp fd", 32'(seen), 32'd1);
      chk("bp ready back", 32'(load_ready), 32'd1);
      tick();
      load_valid = 1'b0;
      chk("bp second taken", 32'(load_ready), 32'd0);
      ticks(B);
      chk("bp first frame", 32'(sseg), 32'h60);
      wait_fd();
      ticks(B + 1);
      chk("bp second frame", 32'(sseg), 32'hFE);
      $display("backpressure sequence done");
    end

    // Boundary collision: transfer on the boundary edge waits a whole frame.
    wait_fd();
    ticks(FR - 1);
    load_digits = 16'h9ABC; load_dp = 4'h0; load_den = 4'hF; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("col fd", 32'(frame_done), 32'd1);
    chk("col ready", 32'(load_ready), 32'd0);
    for (int i = 1; i < FR; i++) begin
      tick();
      chk("col ready held", 32'(load_ready), 32'd0);
      if (i == B + 1) chk("col old frame", 32'(sseg), 32'hFE);
    end
    tick();
    chk("col next fd", 32'(frame_done), 32'd1);
    chk("col ready free", 32'(load_ready), 32'd1);
    ticks(B + 1);
    chk("col new frame", 32'(sseg), 32'h9C);
    $display("boundary collision sequence done");

    // Enable freeze mid slot 2 with digits 0 and 2 disabled.
    do_load(16'h3210, 4'h0, 4'b1010);
    wait_fd();
    ticks(2 * R + 4);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("en0 anode", 32'(anode), 32'd0);
      chk("en0 sseg", 32'(sseg), 32'd0);
      chk("en0 idx", 32'(digit_idx), 32'd2);
    end
    en = 1'b1;
    ticks(3);
    chk("resume idx hold", 32'(digit_idx), 32'd2);
    tick();
    chk("resume idx next", 32'(digit_idx), 32'd3);
    ticks(B + 1);
    chk("resume digit3", 32'(sseg), 32'hF2);
    chk("resume anode3", 32'(anode), 32'h8);
    $display("enable freeze sequence done");

    // Reset during slot 1 with pending full.
    wait_fd();
    do_load(16'h7777, 4'hF, 4'hF);
    ticks(R);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid rst sseg", 32'(sseg), 32'd0);
    chk("mid rst anode", 32'(anode), 32'd0);
    chk("mid rst ready", 32'(load_ready), 32'd1);
    chk("mid rst idx", 32'(digit_idx), 32'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("dark after mid rst", 32'(anode), 32'd0);
    end
    $display("mid-frame reset sequence done");

    // Randomized soak against the model.
    for (int i = 0; i < 1500; i++) begin
      en          = ($urandom_range(0, 9) != 0);
      rst_n       = ($urandom_range(0, 399) != 0);
      load_valid  = ($urandom_range(0, 2) == 0);
      load_digits = 16'($urandom);
      load_dp     = 4'($urandom);
      load_den    = 4'($urandom);
      if (load_valid && load_ready && rst_n)
        $display("rand load digits=%h dp=%b den=%b", load_digits, load_dp, load_den);
      tick();
    end
    load_valid = 1'b0;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Time-multiplexed driver for the 4-digit seven-segment display on the lab board.
- Holds a 4-digit hex frame plus per-digit decimal points and enables.
- Scans the anodes one digit at a time, with an anti-ghosting blank gap at the start of each slot.
- Accepts new frames via a valid/ready handshake and applies them only at frame boundaries, so the display never tears.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (1 kHz per digit at 50 MHz); must be at least 2.
- BLANK_CYC, 500, cycles at the start of each slot with anode forced off; must satisfy 0 <= BLANK_CYC < REFRESH_DIV.
- CNT_W, 16, slot counter width; 2^CNT_W must be at least REFRESH_DIV.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- en  in  1  scan enable; 0 freezes the counters and blanks the outputs.
- load_valid  in  1  new frame offered.
- load_ready  out  1  pending buffer is empty.
- load_digits  in  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3 (leftmost).
- load_dp  in  4  decimal point per digit; bit i belongs to digit i.
- load_den  in  4  digit enable per digit; 0 keeps that digit dark.
- sseg  out  8  segments {a,b,c,d,e,f,g,dp}, active high.
- anode  out  4  one-hot, active high; bit i selects digit i.
- digit_idx  out  2  index of the digit slot currently being scanned.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous, active low. When rst_n=0 at a rising edge:
    - sseg=0, anode=0, digit_idx=0, frame_done=0, load_ready=1.
    - Slot counter = 0.
    - Active frame cleared: digits=0, dp=0, den=0.
    - Pending buffer emptied.
  - Reset mid-frame discards both the pending and the active frame.
- Slot counter (cnt):
  - When en=1, counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit_idx increments 0→1→2→3→0 (2-bit natural wrap).
  - When en=0, cnt and digit_idx hold.
- Frame boundary: the edge where en=1, digit_idx=3 and cnt=REFRESH_DIV-1.
  - If pending is full, the active frame is loaded from pending and pending is cleared.
  - frame_done=1 for exactly the next cycle, whether or not a swap occurred.
- Load handshake:
  - Transfer happens on an edge with load_valid=1 and load_ready=1.
  - The transfer captures load_digits, load_dp and load_den into pending and marks it full.
  - load_ready = pending empty (registered; deasserts the cycle after a transfer).
  - load_valid while load_ready=0: ignored. The source must hold its data.
  - Transfer on the same edge as a frame boundary: the boundary tests pending before capture. The new data waits one full frame; pending is full afterwards.
  - en=0 does not block transfers, but no swap occurs while en=0.
- Outputs are registered: they reflect the (cnt, digit_idx, active frame) state sampled at the previous edge.
  - en=0 or cnt<BLANK_CYC or den[idx]=0: anode=0, sseg=0.
  - Otherwise: anode = one-hot(idx), sseg = {decode(digit[idx]), dp[idx]}.
- Hex decode (7 bits, a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- At most one anode bit is ever high. No anode is high during a blank gap.

Test Plan:
(All scenarios use REFRESH_DIV=8, BLANK_CYC=2, en=1 unless stated.)
- Reset state: hold rst_n=0 for 3 cycles, then release. Required:
  - anode=0, sseg=0 and load_ready=1 at release.
  - No anode high for 32 cycles (all den=0).
- Load and display: load digits=16'h0CE5, den=4'hF, dp=4'b0001; wait for frame_done. Required in the next frame:
  - Slot 0: anode=0001, sseg=10110111 for 6 cycles, after 2 blank cycles.
  - Slot 1: sseg=10011110.
  - Slot 2: sseg=10011100.
  - Slot 3: sseg=11111100.
- Backpressure: two consecutive loads without waiting. Required:
  - load_ready drops after the first transfer; the second load is held off.
  - load_ready returns to 1 the cycle after frame_done; the second frame appears one frame later.
- Boundary collision: load_valid on the exact frame-boundary edge with pending empty. Required:
  - Old frame shown for one more full frame (32 cycles).
  - New frame applied at the following boundary; load_ready stays 0 until then.
- Enable and blanking: clear en mid-slot 2 for 10 cycles. Required:
  - anode=0 and sseg=0 while en=0.
  - digit_idx holds at 2; the scan resumes at the frozen cnt.
  - den=4'b1010 leaves digits 0 and 2 dark.
- Reset mid-frame: apply rst_n=0 during slot 1 with pending full. Required: outputs zero, load_ready=1, digit_idx=0, nothing displayed afterward.
